// File: rtl/rah_decoder_pkg.sv
// Shared definitions for the RAH receive-side line decoder.
// Header field layout, state encoding and error bit positions.
package rah_decoder_pkg;

  localparam int TOTAL_APPS_DEF = 4;

  localparam int APP_ID_LSB = 0;
  localparam int APP_ID_W   = 8;
  localparam int LEN_LSB    = 8;
  localparam int LEN_W      = 16;

  localparam int ERR_APP   = 0;
  localparam int ERR_TRUNC = 1;
  localparam int ERR_CSUM  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DROP    = 3'd3,
    ST_CHECK   = 3'd4
  } dec_state_t;

endpackage

// File: rtl/rah_line_csum.sv
// XOR accumulator over the payload words of one line.
// Only built when RAH_DEC_CHECKSUM_EN is defined.
`ifdef RAH_DEC_CHECKSUM_EN
module rah_line_csum #(
  parameter int DATA_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] csum
);

  // Running XOR, restarted at each accepted header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
    end else if (clr) begin
      csum <= '0;
    end else if (en) begin
      csum <= csum ^ data;
    end
  end

endmodule
`endif

// File: rtl/rah_decoder.sv
// RAH MIPI line decoder: demuxes line payloads to per-app strobes.
// Optional trailing checksum word is enabled by RAH_DEC_CHECKSUM_EN.
module rah_decoder
  import rah_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = 48,
  parameter int TOTAL_APPS = TOTAL_APPS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mipi_valid,
  input  logic [DATA_WIDTH-1:0] mipi_data,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  err_clr,
  output logic [TOTAL_APPS-1:0] rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [15:0]           frame_cnt,
  output logic [2:0]            err_flags
);

  localparam logic [APP_ID_W:0] APP_LIM =
    (APP_ID_W+1)'(TOTAL_APPS);

  dec_state_t state;
  dec_state_t nxt;
  dec_state_t cur;

  logic [APP_ID_W-1:0] hdr_app;
  logic [LEN_W-1:0]    hdr_len;
  logic [APP_ID_W-1:0] app_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [TOTAL_APPS-1:0] sel;

  logic       take;
  logic       strobe;
  logic       last;
  logic       in_line;
  logic [2:0] err_set;
  logic [2:0] err_q;

  assign hdr_app = mipi_data[APP_ID_LSB +: APP_ID_W];
  assign hdr_len = mipi_data[LEN_LSB +: LEN_W];

`ifdef RAH_DEC_CHECKSUM_EN
  logic                  csum_clr;
  logic [DATA_WIDTH-1:0] csum;

  rah_line_csum #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_csum (
    .clk (clk),
    .rst (rst),
    .clr (csum_clr),
    .en  (strobe),
    .data(mipi_data),
    .csum(csum)
  );
`endif

  // Next state, payload strobe and error events for this cycle.
  always_comb begin
    nxt     = state;
    cur     = state;
    take    = 1'b0;
    strobe  = 1'b0;
    last    = 1'b0;
    err_set = '0;
`ifdef RAH_DEC_CHECKSUM_EN
    csum_clr = 1'b0;
    in_line  = (state == ST_PAYLOAD) ||
               (state == ST_CHECK);
`else
    in_line  = (state == ST_PAYLOAD);
`endif
    if ((hsync || vsync) && in_line) begin
      err_set[ERR_TRUNC] = 1'b1;
    end
    if (vsync && !hsync) begin
      nxt = ST_IDLE;
    end else begin
      // A word arriving with hsync is the header.
      cur = hsync ? ST_HEADER : state;
      nxt = cur;
      case (cur)
        ST_HEADER: begin
          if (mipi_valid) begin
            if ({1'b0, hdr_app} >= APP_LIM) begin
              err_set[ERR_APP] = 1'b1;
              nxt = ST_DROP;
            end else if (hdr_len == '0) begin
`ifdef RAH_DEC_CHECKSUM_EN
              csum_clr = 1'b1;
              nxt = ST_CHECK;
`else
              nxt = ST_IDLE;
`endif
            end else begin
`ifdef RAH_DEC_CHECKSUM_EN
              csum_clr = 1'b1;
`endif
              take = 1'b1;
              nxt  = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (mipi_valid) begin
            strobe = 1'b1;
            if (cnt_q == len_q - 1'b1) begin
              last = 1'b1;
`ifdef RAH_DEC_CHECKSUM_EN
              nxt = ST_CHECK;
`else
              nxt = ST_IDLE;
`endif
            end
          end
        end
`ifdef RAH_DEC_CHECKSUM_EN
        ST_CHECK: begin
          if (mipi_valid) begin
            if (mipi_data != csum) begin
              err_set[ERR_CSUM] = 1'b1;
            end
            nxt = ST_IDLE;
          end
        end
`endif
        ST_IDLE: nxt = ST_IDLE;
        ST_DROP: nxt = ST_DROP;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // One-hot decode of the latched app id.
  always_comb begin
    sel = '0;
    for (int i = 0; i < TOTAL_APPS; i++) begin
      sel[i] = (app_q == APP_ID_W'(i));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Line context, word counter and registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      app_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      if (take) begin
        app_q <= hdr_app;
        len_q <= hdr_len;
        cnt_q <= '0;
      end else if (strobe) begin
        cnt_q <= cnt_q + 1'b1;
      end
      rd_valid <= strobe ? sel : '0;
      rd_last  <= last;
      if (strobe) begin
        rd_data <= mipi_data;
      end
    end
  end

  // Sticky errors (set beats clear) and frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= '0;
      frame_cnt <= '0;
    end else begin
      err_q <= (err_clr ? 3'b000 : err_q) | err_set;
      if (vsync) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign err_flags = err_q;

endmodule

// File: tb/tb_rah_decoder.sv
// Scoreboard bench for rah_decoder with four app channels.
// Checksum expectations follow RAH_DEC_CHECKSUM_EN.
module tb_rah_decoder;

  localparam int DW = 48;
  localparam int NA = 4;

`ifdef RAH_DEC_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  typedef struct {
    logic [NA-1:0] v;
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mipi_valid;
  logic [DW-1:0] mipi_data;
  logic          hsync;
  logic          vsync;
  logic          err_clr;
  logic [NA-1:0] rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic [15:0]   frame_cnt;
  logic [2:0]    err_flags;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_frame = '0;

  rah_decoder #(
    .DATA_WIDTH(DW),
    .TOTAL_APPS(NA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mipi_valid(mipi_valid),
    .mipi_data (mipi_data),
    .hsync     (hsync),
    .vsync     (vsync),
    .err_clr   (err_clr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .frame_cnt (frame_cnt),
    .err_flags (err_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] hdr(
    input int app, input int len);
    logic [DW-1:0] h;
    h = '0;
    h[7:0]  = 8'(app);
    h[23:8] = 16'(len);
    h[40]   = 1'b1;
    return h;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [DW-1:0] d,
                       input logic hs,
                       input logic vs);
    mipi_valid = v;
    mipi_data  = d;
    hsync      = hs;
    vsync      = vs;
    @(posedge clk);
    #1;
    mipi_valid = 1'b0;
    hsync      = 1'b0;
    vsync      = 1'b0;
    if (vs) exp_frame = exp_frame + 16'd1;
  endtask

  task automatic pay(input int app,
                     input logic [DW-1:0] d,
                     input logic last);
    exp_t e;
    e.v    = NA'(1) << app;
    e.d    = d;
    e.last = last;
    q.push_back(e);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  // Pops one expectation per presented payload strobe.
  always @(negedge clk) begin
    if (!rst && rd_valid != '0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got %b expected none",
                 rd_valid);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rd_valid !== e.v || rd_data !== e.d ||
            rd_last !== e.last) begin
          errors++;
          $display("FAIL rd_port: got v=%b d=%0h l=%b expected v=%b d=%0h l=%b",
                   rd_valid, rd_data, rd_last,
                   e.v, e.d, e.last);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    rst        = 1'b1;
    mipi_valid = 1'b0;
    mipi_data  = '0;
    hsync      = 1'b0;
    vsync      = 1'b0;
    err_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(rd_valid), 64'h0);
    chk("rst_data", 64'(rd_data), 64'h0);
    chk("rst_err", 64'(err_flags), 64'h0);
    chk("rst_frame", 64'(frame_cnt), 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Normal line: app 2, three words.
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, hdr(2, 3), 1'b0, 1'b0);
    pay(2, 48'hA0A0_0000_000A, 1'b0);
    pay(2, 48'hB0B0_0000_000B, 1'b0);
    pay(2, 48'hC0C0_0000_000C, 1'b1);
    drive(1'b1, 48'hA0A0_0000_000A ^ 48'hB0B0_0000_000B ^
                48'hC0C0_0000_000C, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("normal_err", 64'(err_flags), 64'h0);
    chk("hold_data", 64'(rd_data), 64'hC0C0_0000_000C);

    // Bad app id 7, then five dropped words.
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, hdr(7, 2), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 48'(i + 100), 1'b0, 1'b0);
    chk("badapp_err", 64'(err_flags), 64'h1);
    clr();
    chk("clr_err", 64'(err_flags), 64'h0);

    // Boundary app id = TOTAL_APPS is rejected.
    drive(1'b1, hdr(4, 1), 1'b1, 1'b0);
    drive(1'b1, 48'h44, 1'b0, 1'b0);
    chk("app4_err", 64'(err_flags), 64'h1);
    // Clear and set in same cycle: set wins.
    err_clr = 1'b1;
    drive(1'b1, hdr(5, 1), 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("set_wins", 64'(err_flags), 64'h1);
    clr();

    // Highest valid app, single word line.
    drive(1'b1, hdr(3, 1), 1'b1, 1'b0);
    pay(3, 48'h3333, 1'b1);
    drive(1'b1, 48'h3333, 1'b0, 1'b0);
    chk("app3_err", 64'(err_flags), 64'h0);

    // Truncation by hsync carrying a new header.
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, hdr(1, 10), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      pay(1, 48'(i + 16'h1100), 1'b0);
    drive(1'b1, hdr(0, 1), 1'b1, 1'b0);
    pay(0, 48'hD00D, 1'b1);
    drive(1'b1, 48'hD00D, 1'b0, 1'b0);
    chk("trunc_err", 64'(err_flags), 64'h2);
    clr();

    // Empty line: only a zero checksum follows.
    drive(1'b1, hdr(3, 0), 1'b1, 1'b0);
    drive(1'b1, '0, 1'b0, 1'b0);
    drive(1'b1, 48'h77, 1'b0, 1'b0);
    chk("len0_err", 64'(err_flags), 64'h0);

    // vsync mid-payload aborts the line.
    drive(1'b1, hdr(2, 3), 1'b1, 1'b0);
    pay(2, 48'h2222, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 48'h9999, 1'b0, 1'b0);
    chk("vsync_err", 64'(err_flags), 64'h2);
    chk("vsync_frame", 64'(frame_cnt), 64'(exp_frame));
    clr();

    // Checksum good then bad.
    w0 = 48'h5;
    w1 = 48'h3;
    drive(1'b1, hdr(1, 2), 1'b1, 1'b0);
    pay(1, w0, 1'b0);
    pay(1, w1, 1'b1);
    drive(1'b1, 48'h6, 1'b0, 1'b0);
    chk("csum_good", 64'(err_flags), 64'h0);
    drive(1'b1, hdr(1, 2), 1'b1, 1'b0);
    pay(1, w0, 1'b0);
    pay(1, w1, 1'b1);
    drive(1'b1, 48'h7, 1'b0, 1'b0);
    chk("csum_bad", 64'(err_flags), CS ? 64'h4 : 64'h0);
    clr();

    // Reset asserted while a word is on the read port.
    drive(1'b1, hdr(3, 5), 1'b1, 1'b0);
    pay(3, 48'h3001, 1'b0);
    pay(3, 48'h3002, 1'b0);
    drive(1'b1, 48'h3003, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(rd_valid), 64'h0);
    chk("mid_rst_data", 64'(rd_data), 64'h0);
    chk("mid_rst_last", 64'(rd_last), 64'h0);
    chk("mid_rst_frame", 64'(frame_cnt), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_frame = '0;
    drive(1'b1, hdr(3, 2), 1'b1, 1'b0);
    pay(3, 48'hAB, 1'b0);
    pay(3, 48'hCD, 1'b1);
    drive(1'b1, 48'hAB ^ 48'hCD, 1'b0, 1'b0);
    chk("post_rst_err", 64'(err_flags), 64'h0);

    // Frame counter wraps.
    vsync = 1'b1;
    repeat (16'hFFFF) @(posedge clk);
    #1;
    vsync = 1'b0;
    chk("frame_max", 64'(frame_cnt), 64'hFFFF);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("frame_wrap", 64'(frame_cnt), 64'h0);

    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
